// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared sizes and state encoding for the sort host
//
// Purpose: default job geometry (N words of W bits), index width, and the
// one-hot state encoding used by sort_host.
package sort_pkg;

  localparam int N     = 32;
  localparam int W     = 7;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [4:0] {
    S_LOAD   = 5'b00001,
    S_START  = 5'b00010,
    S_WAIT   = 5'b00100,
    S_UNLOAD = 5'b01000,
    S_ACK    = 5'b10000
  } state_e;

endpackage

// File: rtl/sort_host.sv
// rtl/sort_host.sv - serial load / sorter handshake / serial unload host
//
// Purpose: collects N words from a serial input stream into a packed job,
// hands the job to an external sorter (start/done/ack), captures the sorted
// result and replays it as a serial output stream.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   in_valid/in_data/in_ready            serial word input
//   out_valid/out_data/out_last/out_ready serial sorted output
//   a_flat                 packed unsorted job to the sorter (word i at [i*W +: W])
//   b_flat                 packed sorted result from the sorter
//   start, done, ack       job handshake with the sorter
//   busy                   high whenever not loading
module sort_host
#(
  parameter int N = sort_pkg::N,
  parameter int W = sort_pkg::W
)
(
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  input  logic [W-1:0]   in_data,
  output logic           in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  input  logic           out_ready,
  output logic [N*W-1:0] a_flat,
  input  logic [N*W-1:0] b_flat,
  output logic           start,
  input  logic           done,
  output logic           ack,
  output logic           busy
);

  import sort_pkg::*;

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N*W-1:0]  a_q;
  logic [N*W-1:0]  res_q;
  logic            idx_last;

  assign idx_last = (idx_q == IW'(N - 1));

  // State and the single shared index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Job buffer: written only while loading, so the sorter sees a stable
  // value in every other state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
    end else if (state_q == S_LOAD && in_valid) begin
      a_q[int'(idx_q)*W +: W] <= in_data;
    end
  end

  // Result buffer: captured on the first done seen while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q <= '0;
    end else if (state_q == S_WAIT && done) begin
      res_q <= b_flat;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = S_START;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_START: state_d = S_WAIT;
      // done is only meaningful here; elsewhere a stale level is ignored.
      S_WAIT: begin
        if (done) state_d = S_UNLOAD;
      end
      // out_valid is always high in UNLOAD, so out_ready alone marks a beat.
      S_UNLOAD: begin
        if (out_ready) begin
          if (idx_last) begin
            idx_d   = '0;
            state_d = S_ACK;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_ACK: begin
        if (!done) state_d = S_LOAD;
      end
      default: begin
        state_d = S_LOAD;
        idx_d   = '0;
      end
    endcase
  end

  // All handshake outputs decode only the state/index registers, so no
  // input reaches an output combinationally.
  assign in_ready  = (state_q == S_LOAD);
  assign busy      = (state_q != S_LOAD);
  assign start     = (state_q == S_START);
  assign ack       = (state_q == S_ACK);
  assign out_valid = (state_q == S_UNLOAD);
  assign out_last  = (state_q == S_UNLOAD) && idx_last;
  assign out_data  = (state_q == S_UNLOAD) ? res_q[int'(idx_q)*W +: W] : '0;
  assign a_flat    = a_q;

endmodule

// File: tb/tb_sort_host.sv
// tb/tb_sort_host.sv - self-checking bench for sort_host
module tb_sort_host;

  localparam int NN = 32;
  localparam int WW = 7;

  typedef logic [WW-1:0] job_t [NN];

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic [WW-1:0]   in_data;
  logic            in_ready;
  logic            out_valid;
  logic [WW-1:0]   out_data;
  logic            out_last;
  logic            out_ready;
  logic [NN*WW-1:0] a_flat;
  logic [NN*WW-1:0] b_flat;
  logic            start;
  logic            done;
  logic            ack;
  logic            busy;

  logic model_done;
  logic extra_done;
  assign done = model_done | extra_done;

  int tests_run    = 0;
  int tests_failed = 0;
  int start_count  = 0;
  int done_hold    = 0;

  always #5 clk = ~clk;

  sort_host #(.N(NN), .W(WW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .a_flat(a_flat), .b_flat(b_flat),
    .start(start), .done(done), .ack(ack), .busy(busy)
  );

  function automatic job_t sorted_of(input job_t v);
    int q[$];
    job_t r;
    for (int i = 0; i < NN; i++) q.push_back(int'(v[i]));
    q.sort();
    for (int i = 0; i < NN; i++) r[i] = WW'(q[i]);
    return r;
  endfunction

  function automatic logic [NN*WW-1:0] pack_of(input job_t v);
    logic [NN*WW-1:0] p;
    for (int i = 0; i < NN; i++) p[i*WW +: WW] = v[i];
    return p;
  endfunction

  // Sorter model: acts on falling edges so its outputs are settled well
  // before the DUT samples them.
  initial begin : sorter_model
    int phase, cnt, hold;
    job_t snap;
    model_done = 1'b0;
    b_flat     = '0;
    phase = 0; cnt = 0; hold = 0;
    forever begin
      @(negedge clk);
      if (start === 1'b1) start_count++;
      if (reset) begin
        phase = 0;
        model_done = 1'b0;
      end else begin
        case (phase)
          0: if (start === 1'b1) begin
               for (int i = 0; i < NN; i++) snap[i] = a_flat[i*WW +: WW];
               b_flat = pack_of(sorted_of(snap));
               cnt = 40;
               phase = 1;
             end
          1: begin
               cnt--;
               if (cnt == 0) begin model_done = 1'b1; phase = 2; end
             end
          2: if (ack === 1'b1) begin hold = done_hold; phase = 3; end
          default: begin
               if (hold == 0) begin model_done = 1'b0; phase = 0; end
               else hold--;
             end
        endcase
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1, "timeout");
  end

  task automatic rand_job(output job_t v);
    for (int i = 0; i < NN; i++) v[i] = WW'($urandom);
  endtask

  // Loads a job; returns one cycle after the last accepted beat (in START).
  task automatic do_load(input job_t vals, input bit rnd);
    int k, cyc;
    bit rdy, early;
    k = 0; cyc = 0; early = 0;
    while (k < NN && cyc < 1000) begin
      in_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_data  = in_valid ? vals[k] : WW'($urandom);
      rdy = in_ready;
      if (start !== 1'b0) early = 1;
      @(posedge clk); #1;
      cyc++;
      if (in_valid && rdy) k++;
    end
    in_valid = 1'b0;
    tests_run++;
    if (k != NN || early) begin
      tests_failed++;
      $display("FAIL load_accept: beats=%0d start_early=%0d, want beats=%0d start_early=0", k, early, NN);
    end
    tests_run++;
    if (start !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_after_last_beat: start=%b, want 1", start);
    end
    tests_run++;
    if (a_flat !== pack_of(vals)) begin
      tests_failed++;
      $display("FAIL a_flat_loaded: a_flat=%h, want %h", a_flat, pack_of(vals));
    end
  endtask

  task automatic do_unload(input job_t exp, input int stall_beat, input int stall_cycles,
                           input int stop_after);
    int k, st, cyc, bk, ba, be;
    bit bad_d, bad_l, bad_v;
    k = 0; st = 0; cyc = 0; bk = 0; ba = 0; be = 0;
    bad_d = 0; bad_l = 0; bad_v = 0;
    out_ready = 1'b0;
    while (out_valid !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL unload_wait: out_valid=%b after %0d cycles, want 1", out_valid, cyc);
      return;
    end
    cyc = 0;
    while (k < stop_after && cyc < 500) begin
      if (out_valid !== 1'b1) begin bad_v = 1; break; end
      if (out_data !== exp[k] && !bad_d) begin
        bad_d = 1; bk = k; ba = int'(out_data); be = int'(exp[k]);
      end
      if (out_last !== 1'(k == NN - 1)) bad_l = 1;
      if (k == stall_beat && st < stall_cycles) begin out_ready = 1'b0; st++; end
      else out_ready = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (out_ready) k++;
    end
    out_ready = 1'b0;
    tests_run++;
    if (bad_d) begin
      tests_failed++;
      $display("FAIL unload_data: beat %0d out_data=%0d, want %0d", bk, ba, be);
    end
    tests_run++;
    if (bad_l || bad_v || k != stop_after) begin
      tests_failed++;
      $display("FAIL unload_beats: beats=%0d last_err=%0d valid_drop=%0d, want beats=%0d 0 0",
               k, bad_l, bad_v, stop_after);
    end
    if (stall_beat >= 0) begin
      tests_run++;
      if (st != stall_cycles) begin
        tests_failed++;
        $display("FAIL unload_stall: stalled %0d cycles, want %0d", st, stall_cycles);
      end
    end
    if (stop_after == NN) begin
      tests_run++;
      if (out_valid !== 1'b0 || ack !== 1'b1) begin
        tests_failed++;
        $display("FAIL unload_end: out_valid=%b ack=%b, want out_valid=0 ack=1", out_valid, ack);
      end
    end
  endtask

  task automatic wait_load();
    int cyc;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    tests_run++;
    if (in_ready !== 1'b1 || ack !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL return_to_load: in_ready=%b ack=%b busy=%b, want 1 0 0", in_ready, ack, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; extra_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({in_ready, out_valid, out_last, start, ack, busy} !== 6'b100000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: in_ready,out_valid,out_last,start,ack,busy=%b, want 100000",
               {in_ready, out_valid, out_last, start, ack, busy});
    end
    tests_run++;
    if (out_data !== '0 || a_flat !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: out_data=%0d a_flat=%h, want 0 0", out_data, a_flat);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    job_t v, e;
    int s0;
    for (int i = 0; i < NN; i++) begin v[i] = WW'(NN - 1 - i); e[i] = WW'(i); end
    s0 = start_count;
    do_load(v, 1'b0);
    do_unload(e, -1, 0, NN);
    wait_load();
    tests_run++;
    if (start_count - s0 != 1) begin
      tests_failed++;
      $display("FAIL start_pulses: %0d, want 1", start_count - s0);
    end
  endtask

  task automatic test_random_valid();
    job_t v;
    rand_job(v);
    do_load(v, 1'b1);
    // Junk on the input while busy must not reach a_flat.
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = WW'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tests_run++;
    if (a_flat !== pack_of(v) || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL a_flat_stable_busy: a_flat=%h in_ready=%b, want %h 0", a_flat, in_ready, pack_of(v));
    end
    do_unload(sorted_of(v), -1, 0, NN);
    wait_load();
  endtask

  task automatic test_stall();
    job_t v;
    rand_job(v);
    do_load(v, 1'b1);
    do_unload(sorted_of(v), 7, 5, NN);
    wait_load();
  endtask

  task automatic test_ack_hold();
    job_t v;
    int cyc, dhi;
    bit bad;
    rand_job(v);
    done_hold = 3;
    do_load(v, 1'b0);
    do_unload(sorted_of(v), -1, 0, NN);
    cyc = 0; dhi = 0; bad = 0;
    while (ack === 1'b1 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
      // done seen here is the level the DUT sampled on this edge.
      if (done === 1'b1) begin
        dhi++;
        if (ack !== 1'b1) bad = 1;
      end else if (ack !== 1'b0 || in_ready !== 1'b1) begin
        bad = 1;
      end
    end
    done_hold = 0;
    tests_run++;
    if (bad || dhi < 3 || ack !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ack_hold: rule_err=%0d done_high=%0d ack=%b in_ready=%b, want 0 >=3 0 1",
               bad, dhi, ack, in_ready);
    end
  endtask

  task automatic test_reset_mid_unload();
    job_t v, sevens;
    bit seen;
    rand_job(v);
    do_load(v, 1'b1);
    do_unload(sorted_of(v), -1, 0, 12);
    reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || a_flat !== '0 || out_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_unload: out_valid=%b in_ready=%b busy=%b a_flat=%h out_data=%0d, want 0 1 0 0 0",
               out_valid, in_ready, busy, a_flat, out_data);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1;
    end
    out_ready = 1'b0;
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL no_beats_after_reset: out_valid seen=1, want 0");
    end
    for (int i = 0; i < NN; i++) sevens[i] = WW'(7);
    do_load(sevens, 1'b0);
    do_unload(sevens, -1, 0, NN);
    wait_load();
  endtask

  task automatic test_stale_done();
    job_t v;
    rand_job(v);
    extra_done = 1'b1;
    do_load(v, 1'b0);
    // In START with done high and input junk offered.
    in_valid = 1'b1; in_data = ~v[0];
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || start !== 1'b0) begin
      tests_failed++;
      $display("FAIL stale_done_start: out_valid=%b busy=%b start=%b, want 0 1 0", out_valid, busy, start);
    end
    extra_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = WW'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || a_flat !== pack_of(v)) begin
      tests_failed++;
      $display("FAIL stale_done_wait: out_valid=%b a_flat=%h, want 0 %h", out_valid, a_flat, pack_of(v));
    end
    do_unload(sorted_of(v), -1, 0, NN);
    wait_load();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_random_valid();
    test_stall();
    test_ack_hold();
    test_reset_mid_unload();
    test_stale_done();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sort_host.md
SORT_HOST -- requirements
Module: sort_host

Interface
REQ-001 SHALL use parameter N, default 32, number of words per sort job.
REQ-002 SHALL use parameter W, default 7, bit width of each word.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, named clk and reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have ports in_valid input 1 / in_data input W / in_ready output 1: serial word input stream.
REQ-007 SHALL have ports out_valid output 1 / out_data output W / out_last output 1 / out_ready input 1: serial sorted-word output stream.
REQ-008 SHALL have port a_flat  output  N*W  unsorted job to the sorter; word i is at bits [i*W +: W].
REQ-009 SHALL have port b_flat  input  N*W  sorted result from the sorter, packed the same way.
REQ-010 SHALL have ports start output 1, done input 1 and ack output 1: job handshake with the sorter.
REQ-011 SHALL have port busy  output  1  high in every state except LOAD.

Function
REQ-012 SHALL implement FSM states LOAD, START, WAIT, UNLOAD and ACK, plus a shared index idx of width clog2(N).
REQ-013 LOAD SHALL hold in_ready=1, and each beat with in_valid=1 SHALL write in_data to a_flat word idx and then increment idx.
REQ-014 Acceptance of the beat at idx=N-1 SHALL clear idx and move the FSM to START on the next cycle.
REQ-015 START SHALL assert start for exactly one cycle and then move unconditionally to WAIT.
REQ-016 WAIT SHALL keep start=0, and on the first cycle done=1 is sampled it SHALL capture b_flat into an internal result buffer and move to UNLOAD.
REQ-017 UNLOAD SHALL drive out_valid=1 with out_data = result word idx, and SHALL assert out_last only when idx=N-1.
REQ-018 In UNLOAD, idx SHALL advance only on out_valid&&out_ready, and out_data SHALL stay stable while the beat is stalled.
REQ-019 Acceptance of the beat with out_last=1 SHALL clear idx and move the FSM to ACK.
REQ-020 ACK SHALL hold ack=1 until done is sampled low, then deassert ack and move to LOAD; ACK therefore lasts at least one cycle.
REQ-021 a_flat SHALL remain registered and stable in every state except LOAD, because the sorter samples it continuously while idle.
REQ-022 in_ready SHALL be 0 outside LOAD, and in_valid outside LOAD SHALL be ignored with no write.
REQ-023 done SHALL be ignored in LOAD, START and UNLOAD, so a stale done cannot advance the FSM.
REQ-024 out_valid, out_last, start and ack SHALL all be registered outputs with no combinational input-to-output path.
REQ-025 Minimum job latency SHALL be N load cycles + 1 START + sorter time + N unload cycles + 1 or more ACK cycles.

Reset
REQ-026 While reset is high, the FSM SHALL be in LOAD, idx SHALL be 0, and a_flat and the result buffer SHALL be all zero.
REQ-027 Reset values SHALL be in_ready=1, out_valid=0, out_data=0, out_last=0, start=0, ack=0, busy=0.
REQ-028 Reset asserted mid-job SHALL abort immediately, discard partial load or unload data, and emit no further out beats.

Structure
REQ-029 Shared package sort_pkg SHALL hold N, W, the index width and the one-hot state encoding (LOAD=5'b00001 ... ACK=5'b10000).
REQ-030 The block SHALL be a single flat module with no sub-module, and idx SHALL be the only counter.

Verification
REQ-031 The bench SHALL load 31,30,...,0 back-to-back using a sorter model (done 40 cycles after start) and SHALL see out 0..31 in order, out_last only on value 31, and one start pulse.
REQ-032 The bench SHALL toggle in_valid 50% random during load and SHALL see a_flat equal to the loaded sequence, with start issued only after the 32nd accepted beat.
REQ-033 The bench SHALL hold out_ready=0 for 5 cycles on beat 7 and SHALL see out_data stable at word 7 and idx frozen, with no beat lost or duplicated.
REQ-034 The bench SHALL have the model hold done high for 3 cycles after ack and SHALL see ack stay high until done falls, then in_ready=1 the next cycle.
REQ-035 The bench SHALL assert reset during UNLOAD at beat 12 and SHALL see out_valid=0 at once, the LOAD state, and a_flat=0; a following job of all-7s SHALL return 32 beats of 7.
REQ-036 The bench SHALL drive done=1 and in_valid=1 during START/WAIT entry and SHALL see no early UNLOAD and no a_flat write.
